if_latch: RTL and testbench

IF_LATCH -- requirements
Module: if_latch

---
 rtl/if_latch.sv | 131 +++++++++++++
 tb/tb_if_latch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_latch.sv
// IF/ID boundary: fetch request generation, ID latch, one-entry skid buffer for
// stalled fetches, and redirect/HALT handling.
module if_latch (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pcaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        stall,
  input  logic        flush,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        pcen,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pcplus4,
  output logic        id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, KILL, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] buf_instr, buf_pcplus4, kill_addr;
  logic        ld_fetch, ld_buf_id, ld_buf, ld_kill, clr_valid;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == 6'h3F;
  endfunction

  always_comb begin
    state_nxt = state;
    imemREN   = 1'b0;
    imemaddr  = pcaddr;
    pcen      = 1'b0;
    ld_fetch  = 1'b0;
    ld_buf_id = 1'b0;
    ld_buf    = 1'b0;
    ld_kill   = 1'b0;
    clr_valid = 1'b0;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (flush) begin
          pcen      = 1'b1;
          clr_valid = 1'b1;
          if (!ihit) begin
            ld_kill   = 1'b1;
            state_nxt = KILL;
          end
        end else if (ihit) begin
          pcen = 1'b1;
          if (stall) begin
            ld_buf    = 1'b1;
            state_nxt = HOLD;
          end else begin
            ld_fetch  = 1'b1;
            state_nxt = is_halt(imemload) ? HALTED : FETCH;
          end
        end else if (!stall) begin
          clr_valid = 1'b1;
        end
      end
      HOLD: begin
        // A buffered HALT still reaches ID before fetch stops.
        if (flush) begin
          pcen      = 1'b1;
          clr_valid = 1'b1;
          state_nxt = FETCH;
        end else if (!stall) begin
          ld_buf_id = 1'b1;
          state_nxt = is_halt(buf_instr) ? HALTED : FETCH;
        end
      end
      KILL: begin
        // Drain the in-flight read for the squashed address; its data is dropped.
        imemREN  = 1'b1;
        imemaddr = kill_addr;
        if (flush) begin
          pcen      = 1'b1;
          clr_valid = 1'b1;
        end
        if (ihit) state_nxt = FETCH;
      end
      HALTED: begin
        if (flush) begin
          pcen      = 1'b1;
          clr_valid = 1'b1;
          state_nxt = FETCH;
        end else if (!stall) begin
          clr_valid = 1'b1;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      id_instruction <= '0;
      id_pcplus4     <= '0;
      id_valid       <= 1'b0;
      buf_instr      <= '0;
      buf_pcplus4    <= '0;
      kill_addr      <= '0;
    end else begin
      if (ld_fetch) begin
        id_instruction <= imemload;
        id_pcplus4     <= pc_plus4(pcaddr);
      end else if (ld_buf_id) begin
        id_instruction <= buf_instr;
        id_pcplus4     <= buf_pcplus4;
      end
      if (ld_fetch || ld_buf_id) id_valid <= 1'b1;
      else if (clr_valid)        id_valid <= 1'b0;
      if (ld_buf) begin
        buf_instr   <= imemload;
        buf_pcplus4 <= pc_plus4(pcaddr);
      end
      if (ld_kill) kill_addr <= pcaddr;
    end
  end

endmodule

// File: tb/tb_if_latch.sv
// Directed and randomized bench for if_latch against a queue/flag based
// reference model of the fetch latch behaviour.
module tb_if_latch;

  logic        CLK, RST;
  logic [31:0] pcaddr, imemload;
  logic        ihit, stall, flush;
  logic        imemREN, pcen, id_valid;
  logic [31:0] imemaddr, id_instruction, id_pcplus4;

  int total = 0;
  int bad   = 0;

  if_latch dut (
    .CLK(CLK), .RST(RST), .pcaddr(pcaddr), .imemload(imemload), .ihit(ihit),
    .stall(stall), .flush(flush), .imemREN(imemREN), .imemaddr(imemaddr),
    .pcen(pcen), .id_instruction(id_instruction), .id_pcplus4(id_pcplus4),
    .id_valid(id_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: pending stalled fetches in a queue, plus flags for an
  // outstanding squashed read and for a halted front end.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } ent_t;

  ent_t        pend_q[$];
  bit          killing, halted;
  logic [31:0] kaddr, m_ins, m_pc4;
  bit          m_valid;

  function automatic bit halt_word(input logic [31:0] w);
    return (w >> 26) == 32'h3F;
  endfunction

  task automatic m_reset();
    pend_q.delete();
    killing = 0; halted = 0; kaddr = 0;
    m_ins = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("id_instruction", id_instruction, m_ins);
    chk("id_pcplus4", id_pcplus4, m_pc4);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
  endtask

  // One clock: drive inputs, check fetch-side outputs, clock, check ID latch.
  task automatic step(input logic [31:0] pc, input logic [31:0] w,
                      input bit ih, input bit st, input bit fl);
    bit   in_hold, in_kill, in_halt, in_fetch;
    ent_t e;
    pcaddr = pc; imemload = w; ihit = ih; stall = st; flush = fl;
    #2;
    in_hold  = pend_q.size() > 0;
    in_kill  = !in_hold && killing;
    in_halt  = !in_hold && !killing && halted;
    in_fetch = !(in_hold || in_kill || in_halt);
    chk("imemREN", {31'd0, imemREN}, {31'd0, (in_fetch || in_kill)});
    chk("imemaddr", imemaddr, in_kill ? kaddr : pc);
    chk("pcen", {31'd0, pcen}, {31'd0, (fl || (in_fetch && ih))});
    @(posedge CLK);
    if (in_hold) begin
      if (fl) begin
        pend_q.delete(); m_valid = 0;
      end else if (!st) begin
        e = pend_q.pop_front();
        m_ins = e.ins; m_pc4 = e.pc4; m_valid = 1;
        halted = halt_word(e.ins);
      end
    end else if (in_kill) begin
      if (fl) m_valid = 0;
      if (ih) killing = 0;
    end else if (in_halt) begin
      if (fl) begin
        halted = 0; m_valid = 0;
      end else if (!st) m_valid = 0;
    end else begin
      if (fl) begin
        m_valid = 0;
        if (!ih) begin killing = 1; kaddr = pc; end
      end else if (ih && !st) begin
        m_ins = w; m_pc4 = pc + 32'd4; m_valid = 1;
        halted = halt_word(w);
      end else if (ih) begin
        e.ins = w; e.pc4 = pc + 32'd4;
        pend_q.push_back(e);
      end else if (!st) m_valid = 0;
    end
    #1;
    chk_regs();
  endtask

  initial begin
    logic [31:0] r, pc, w;
    bit ih, st, fl;
    m_reset();
    RST = 1'b1; pcaddr = 32'h100; imemload = 0; ihit = 0; stall = 0; flush = 0;
    #3;
    chk_regs();
    chk("reset_imemREN", {31'd0, imemREN}, 32'd1);
    chk("reset_imemaddr", imemaddr, 32'h100);
    chk("reset_pcen", {31'd0, pcen}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Plain accept
    step(32'h100, 32'h8C220004, 1, 0, 0);
    chk("accept_instr", id_instruction, 32'h8C220004);
    chk("accept_pc4", id_pcplus4, 32'h104);

    // Stalled accept into the buffer, then release
    step(32'h200, 32'h12345678, 1, 1, 0);
    step(32'h204, 32'hDEADBEEF, 1, 1, 0);
    step(32'h204, 32'hDEADBEEF, 1, 0, 0);
    chk("hold_release_pc4", id_pcplus4, 32'h204);
    chk("hold_release_instr", id_instruction, 32'h12345678);

    // Flush with no hit -> KILL, drain, resume
    step(32'h300, 32'h0, 0, 0, 1);
    step(32'h400, 32'h0, 0, 0, 0);
    step(32'h400, 32'hAAAA5555, 1, 0, 0);
    chk("kill_discard_valid", {31'd0, id_valid}, 32'd0);
    step(32'h400, 32'h11111111, 1, 0, 0);

    // HALT accepted directly, then released by flush
    step(32'h500, 32'hFC000000, 1, 0, 0);
    step(32'h504, 32'h22222222, 1, 0, 0);
    step(32'h504, 32'h22222222, 1, 1, 1);
    step(32'h600, 32'h33333333, 1, 0, 0);

    // HALT accepted through the buffer
    step(32'h700, 32'hFC000001, 1, 1, 0);
    step(32'h704, 32'h44444444, 1, 0, 0);
    chk("buffered_halt_delivered", id_instruction, 32'hFC000001);
    step(32'h704, 32'h44444444, 1, 0, 0);
    step(32'h704, 32'h44444444, 0, 0, 1);

    // Asynchronous reset while in KILL
    step(32'h800, 32'h0, 0, 0, 1);
    step(32'h900, 32'h0, 0, 1, 0);
    pcaddr = 32'h900; ihit = 0; stall = 0; flush = 0;
    RST = 1'b1;
    #1;
    m_reset();
    chk_regs();
    chk("rst_kill_imemREN", {31'd0, imemREN}, 32'd1);
    chk("rst_kill_imemaddr", imemaddr, 32'h900);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Wraparound of pc+4
    step(32'hFFFFFFFC, 32'h01234567, 1, 0, 0);
    chk("wrap_pc4", id_pcplus4, 32'h00000000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = $urandom;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : (r & 32'hFFFFFFFC);
      w  = $urandom;
      if ($urandom_range(0, 9) == 0) w = 32'hFC000000 | (w & 32'h03FFFFFF);
      ih = $urandom_range(0, 9) < 7;
      st = $urandom_range(0, 9) < 3;
      fl = $urandom_range(0, 9) == 0;
      step(pc, w, ih, st, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
